mdio_frame_engine: RTL and testbench

Serial MDIO management-frame engine for the Ethernet MAC. Sits directly behind the MDIO register interface (implements its `in` side): accepts a 32-bit Clause-22 frame word, generates MDC, shifts the frame out on MDIO, and returns 16-bit read data. Drives the external MDC/MDIO pins through a tri-state pad (`mdio_o`/`mdio_oe`/`mdio_i`).

---
 rtl/mdio_frame_engine.sv | 223 ++++++++++++++++++++++
 tb/tb_mdio_frame_engine.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_frame_engine.sv
`default_nettype none
// ============================================================================
// Module   : mdio_frame_engine
// Purpose  : Clause-22 MDIO frame engine; generates MDC, shifts frames out on
//            MDIO and captures read data. MDIO_PREAMBLE_EN adds the 32-bit
//            preamble; when undefined, preamble is suppressed.
// Revision : 1.0 - initial release
// ============================================================================
module mdio_frame_engine #(
    parameter int CLK_DIV = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] transmit_data_in,
    input  logic        transmit_we,
    input  logic        receive_re,
    output logic [15:0] receive_data,
    output logic        receive_valid,
    output logic        transmit_ready,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_HEADER   = 3'd2,
        S_TA       = 3'd3,
        S_DATA     = 3'd4,
        S_GAP      = 3'd5
    } state_t;

    localparam logic [7:0] C_DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic        mdc_q, mdc_d;
    logic [5:0]  bit_q, bit_d;
    logic [31:0] sreg_q, sreg_d;
    logic        is_read_q, is_read_d;
    logic [15:0] rx_shift_q, rx_shift_d;
    logic [15:0] receive_data_q, receive_data_d;
    logic        receive_valid_q, receive_valid_d;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_oe_q, mdio_oe_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic        sync1_q, sync2_q;

    logic w_tick, w_rise_ev, w_bit_end;

    assign w_tick    = (div_q == C_DIV_LAST);
    assign w_rise_ev = w_tick & ~mdc_q;
    assign w_bit_end = w_tick &  mdc_q;

    always_comb begin
        state_d         = state_q;
        div_d           = div_q;
        mdc_d           = mdc_q;
        bit_d           = bit_q;
        sreg_d          = sreg_q;
        is_read_d       = is_read_q;
        rx_shift_d      = rx_shift_q;
        receive_data_d  = receive_data_q;
        receive_valid_d = receive_valid_q;
        mdio_o_d        = mdio_o_q;
        mdio_oe_d       = mdio_oe_q;

        // Acknowledge first so that a same-cycle completion below overrides it.
        if (receive_re) begin
            receive_valid_d = 1'b0;
        end

        if (state_q != S_IDLE) begin
            div_d = w_tick ? 8'd0 : div_q + 8'd1;
            if (w_tick) begin
                mdc_d = ~mdc_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                mdc_d = 1'b0;
                div_d = 8'd0;
                if (transmit_we) begin
                    sreg_d    = transmit_data_in;
                    is_read_d = (transmit_data_in[29:28] == 2'b10);
                    bit_d     = 6'd0;
                    mdio_oe_d = 1'b1;
`ifdef MDIO_PREAMBLE_EN
                    state_d   = S_PREAMBLE;
                    mdio_o_d  = 1'b1;
`else
                    state_d   = S_HEADER;
                    mdio_o_d  = transmit_data_in[31];
`endif
                end
            end
            S_PREAMBLE: begin
                if (w_bit_end) begin
                    if (bit_q == 6'd31) begin
                        state_d  = S_HEADER;
                        bit_d    = 6'd0;
                        mdio_o_d = sreg_q[31];
                    end else begin
                        bit_d = bit_q + 6'd1;
                    end
                end
            end
            S_HEADER: begin
                if (w_bit_end) begin
                    sreg_d = {sreg_q[30:0], 1'b0};
                    if (bit_q == 6'd13) begin
                        state_d   = S_TA;
                        bit_d     = 6'd0;
                        mdio_o_d  = is_read_q ? 1'b1 : sreg_q[30];
                        mdio_oe_d = ~is_read_q;
                    end else begin
                        bit_d    = bit_q + 6'd1;
                        mdio_o_d = sreg_q[30];
                    end
                end
            end
            S_TA: begin
                if (w_bit_end) begin
                    sreg_d   = {sreg_q[30:0], 1'b0};
                    mdio_o_d = is_read_q ? 1'b1 : sreg_q[30];
                    if (bit_q == 6'd1) begin
                        state_d = S_DATA;
                        bit_d   = 6'd0;
                    end else begin
                        bit_d = bit_q + 6'd1;
                    end
                end
            end
            S_DATA: begin
                if (w_rise_ev && is_read_q) begin
                    rx_shift_d = {rx_shift_q[14:0], sync2_q};
                end
                if (w_bit_end) begin
                    sreg_d = {sreg_q[30:0], 1'b0};
                    if (bit_q == 6'd15) begin
                        state_d   = S_GAP;
                        bit_d     = 6'd0;
                        mdio_o_d  = 1'b1;
                        mdio_oe_d = 1'b0;
                    end else begin
                        bit_d    = bit_q + 6'd1;
                        mdio_o_d = is_read_q ? 1'b1 : sreg_q[30];
                    end
                end
            end
            S_GAP: begin
                if (w_bit_end) begin
                    state_d = S_IDLE;
                    bit_d   = 6'd0;
                    if (is_read_q) begin
                        receive_data_d  = rx_shift_q;
                        receive_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                mdc_d     = 1'b0;
                mdio_o_d  = 1'b1;
                mdio_oe_d = 1'b0;
            end
        endcase

        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            div_q           <= 8'd0;
            mdc_q           <= 1'b0;
            bit_q           <= 6'd0;
            sreg_q          <= 32'd0;
            is_read_q       <= 1'b0;
            rx_shift_q      <= 16'd0;
            receive_data_q  <= 16'd0;
            receive_valid_q <= 1'b0;
            mdio_o_q        <= 1'b1;
            mdio_oe_q       <= 1'b0;
            busy_q          <= 1'b0;
            ready_q         <= 1'b1;
            sync1_q         <= 1'b1;
            sync2_q         <= 1'b1;
        end else begin
            state_q         <= state_d;
            div_q           <= div_d;
            mdc_q           <= mdc_d;
            bit_q           <= bit_d;
            sreg_q          <= sreg_d;
            is_read_q       <= is_read_d;
            rx_shift_q      <= rx_shift_d;
            receive_data_q  <= receive_data_d;
            receive_valid_q <= receive_valid_d;
            mdio_o_q        <= mdio_o_d;
            mdio_oe_q       <= mdio_oe_d;
            busy_q          <= busy_d;
            ready_q         <= ready_d;
            sync1_q         <= mdio_i;
            sync2_q         <= sync1_q;
        end
    end

    assign receive_data   = receive_data_q;
    assign receive_valid  = receive_valid_q;
    assign transmit_ready = ready_q;
    assign busy           = busy_q;
    assign mdc            = mdc_q;
    assign mdio_o         = mdio_o_q;
    assign mdio_oe        = mdio_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_mdio_frame_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdio_frame_engine
// Purpose  : Self-checking bench for mdio_frame_engine (CLK_DIV=4), with or
//            without MDIO_PREAMBLE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdio_frame_engine;

    localparam int CDIV = 4;
`ifdef MDIO_PREAMBLE_EN
    localparam int PRE = 1;
`else
    localparam int PRE = 0;
`endif
    localparam int NBITS   = PRE ? 64 : 32;
    localparam int LEN     = (NBITS + 1) * 2 * CDIV;
    localparam int DSTART  = NBITS - 16;
    localparam int RST_BIT = PRE ? 40 : 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] transmit_data_in = 32'd0;
    logic        transmit_we = 1'b0;
    logic        receive_re = 1'b0;
    logic [15:0] receive_data;
    logic        receive_valid;
    logic        transmit_ready;
    logic        busy;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i;

    mdio_frame_engine #(.CLK_DIV(CDIV)) dut (
        .clk              (clk),
        .reset            (reset),
        .transmit_data_in (transmit_data_in),
        .transmit_we      (transmit_we),
        .receive_re       (receive_re),
        .receive_data     (receive_data),
        .receive_valid    (receive_valid),
        .transmit_ready   (transmit_ready),
        .busy             (busy),
        .mdc              (mdc),
        .mdio_o           (mdio_o),
        .mdio_oe          (mdio_oe),
        .mdio_i           (mdio_i)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // PHY model: drives read data bit j during frame bit DSTART+j, counted by MDC falls.
    logic [15:0]  phy_data = 16'd0;
    int           fcount = 0;
    logic [127:0] cap_o = '0, cap_oe = '0;
    int           ncap = 0;

    always @(posedge busy) begin
        fcount = 0;
        ncap   = 0;
        cap_o  = '0;
        cap_oe = '0;
    end
    always @(negedge mdc) fcount++;
    always @(posedge mdc) begin
        if (busy) begin
            cap_o  = {cap_o[126:0], mdio_o};
            cap_oe = {cap_oe[126:0], mdio_oe};
            ncap++;
        end
    end
    always_comb begin
        mdio_i = 1'b1;
        if (fcount >= DSTART && fcount < DSTART + 16)
            mdio_i = phy_data[15 - (fcount - DSTART)];
    end

    logic [15:0] exp_q[$];
    logic        exp_valid = 1'b0;
    logic [15:0] exp_data  = 16'd0;

    typedef struct {
        logic [31:0] word;
        logic [15:0] phy;
    } vec_t;
    vec_t vecs[6];

    task automatic build_exp(input logic [31:0] w, input logic rd,
                             output logic [127:0] eo, output logic [127:0] eoe,
                             output logic [127:0] m);
        eo = '0; eoe = '0; m = '0;
        if (PRE) begin
            for (int i = 0; i < 32; i++) begin
                eo = {eo[126:0], 1'b1}; eoe = {eoe[126:0], 1'b1}; m = {m[126:0], 1'b1};
            end
        end
        for (int i = 31; i >= 0; i--) begin
            if (!rd || i >= 18) begin
                eo = {eo[126:0], w[i]}; eoe = {eoe[126:0], 1'b1}; m = {m[126:0], 1'b1};
            end else begin
                eo = {eo[126:0], 1'b0}; eoe = {eoe[126:0], 1'b0}; m = {m[126:0], 1'b0};
            end
        end
        eo = {eo[126:0], 1'b1}; eoe = {eoe[126:0], 1'b0}; m = {m[126:0], 1'b1};
    endtask

    task automatic run_frame(input logic [31:0] w, input logic [15:0] phy,
                             input int inj, input logic re_end, input int rst_at);
        logic         rd;
        logic         vbefore;
        logic         aborted;
        int           cyc;
        int           badv;
        logic [127:0] eo, eoe, m;
        rd = (w[29:28] == 2'b10);
        phy_data = phy;
        @(negedge clk);
        chk("ready_pre", transmit_ready, 1);
        transmit_data_in = w;
        transmit_we = 1'b1;
        if (rd) exp_q.push_back(phy);
        @(posedge clk); #1;
        transmit_we = 1'b0;
        chk("busy_rise", {busy, transmit_ready}, 2'b10);
        chk("first_bit", {mdio_oe, mdio_o}, {1'b1, PRE ? 1'b1 : w[31]});
        vbefore = receive_valid;
        cyc = 1; badv = 0; aborted = 0;
        while (busy && cyc < 3000) begin
            if (inj != 0 && cyc == inj) begin
                transmit_data_in = 32'h5000_FFFF;
                transmit_we = 1'b1;
            end else if (inj != 0 && cyc == inj + 1) begin
                transmit_we = 1'b0;
            end
            if (re_end && cyc == LEN) receive_re = 1'b1;
            if (rst_at != 0 && cyc == rst_at) begin
                reset = 1'b1;
                #1;
                chk("rst_async", {mdc, mdio_oe, busy, transmit_ready, receive_valid, mdio_o},
                    6'b000101);
                @(negedge clk);
                reset = 1'b0;
                aborted = 1;
                break;
            end
            if (receive_valid !== vbefore) badv++;
            @(posedge clk); #1;
            if (busy) cyc++;
        end
        receive_re = 1'b0;
        if (aborted) begin
            if (rd) void'(exp_q.pop_back());
            exp_valid = 1'b0;
            exp_data  = 16'd0;
            chk("rst_data", receive_data, 16'd0);
            return;
        end
        chk("valid_hold", badv, 0);
        chk("busy_len", cyc, LEN);
        chk("end_ready", {transmit_ready, mdc, mdio_oe}, 3'b100);
        chk("nbits", ncap, NBITS + 1);
        build_exp(w, rd, eo, eoe, m);
        chk("serial_o", cap_o & m, eo & m);
        chk("serial_oe", cap_oe, eoe);
        if (rd) begin
            exp_valid = 1'b1;
            if (exp_q.size() != 0) exp_data = exp_q.pop_front();
        end
        chk("rx_valid", receive_valid, exp_valid);
        chk("rx_data", receive_data, exp_data);
    endtask

    initial begin
        vecs[0] = '{32'h5082_1234, 16'h0000};
        vecs[1] = '{32'h6082_0000, 16'hA5C3};
        vecs[2] = '{32'h6BFE_0000, 16'h5A3C};
        vecs[3] = '{32'h7FFF_0000, 16'h0000};
        vecs[4] = '{32'h5C3E_ABCD, 16'h0000};
        vecs[5] = '{32'h6000_0000, 16'hFFFF};

        reset = 1'b1;
        #1;
        chk("reset_out", {receive_data, receive_valid, transmit_ready, busy, mdc, mdio_o, mdio_oe},
            {16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 6; i++)
            run_frame(vecs[i].word, vecs[i].phy, 0, 1'b0, 0);

        // Acknowledge, then a stray acknowledge with nothing pending.
        @(negedge clk); receive_re = 1'b1;
        @(posedge clk); #1; receive_re = 1'b0;
        chk("re_clear", receive_valid, 0);
        exp_valid = 1'b0;
        @(negedge clk); receive_re = 1'b1;
        @(posedge clk); #1; receive_re = 1'b0;
        chk("re_idle", {receive_valid, receive_data}, {1'b0, exp_data});

        // Completion coincident with acknowledge keeps valid set.
        run_frame(32'h6083_0000, 16'h0001, 0, 1'b0, 0);
        run_frame(32'h6104_0000, 16'h8000, 0, 1'b1, 0);
        @(posedge clk); #1;
        chk("re_coinc", {receive_valid, receive_data}, {1'b1, 16'h8000});

        // Write strobe mid-frame must be ignored.
        run_frame(32'h5082_1234, 16'h0000, 100, 1'b0, 0);
        begin
            int busy_seen = 0;
            repeat (40) begin
                @(posedge clk); #1;
                if (busy || !transmit_ready) busy_seen++;
            end
            chk("no_second", busy_seen, 0);
        end

        // Reset mid-read, then a normal write.
        run_frame(32'h6082_0000, 16'h1357, 0, 1'b0, RST_BIT * 2 * CDIV);
        repeat (3) @(posedge clk); #1;
        chk("post_rst", {busy, transmit_ready, receive_valid}, 3'b010);
        run_frame(32'h5AA5_5555, 16'h0000, 0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
